// File: rtl/fsm_rx.sv
`default_nettype none
// ============================================================================
// Module   : fsm_rx
// Purpose  : Moves bytes from the UART receiver into the RX FIFO, pulses the
//            "new data" bit, counts written bytes and flags dropped ones.
// Revision : 1.0
// ============================================================================
module fsm_rx #(
   parameter int DATA_W  = 8,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rx_rdy,
   input  logic [DATA_W-1:0]  uart_rx_data,
   input  logic               fifo_rx_full,
   output logic               fifo_rx_wr,
   output logic [DATA_W-1:0]  fifo_rx_din,
   output logic               recibir_bit_set,
   input  logic               overflow_clear,
   input  logic               count_clear,
   output logic               rx_overflow,
   output logic [COUNT_W-1:0] rx_count
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CHECK_FIFO = 2'd1,
      WRITE_FIFO = 2'd2,
      UPDATE     = 2'd3
   } state_t;

   localparam logic [COUNT_W-1:0] C_COUNT_MAX = {COUNT_W{1'b1}};

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                pend_valid_q, pend_valid_d;
   logic [DATA_W-1:0]   pend_data_q, pend_data_d;
   logic                wr_q, wr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                set_q, set_d;
   logic                ovf_q, ovf_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                w_ovf_set;
   logic                w_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         data_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         wr_q         <= 1'b0;
         din_q        <= '0;
         set_q        <= 1'b0;
         ovf_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         wr_q         <= wr_d;
         din_q        <= din_d;
         set_q        <= set_d;
         ovf_q        <= ovf_d;
         count_q      <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      wr_d         = 1'b0;
      din_d        = din_q;
      set_d        = 1'b0;
      w_ovf_set    = 1'b0;
      w_inc        = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_valid_q) begin
               data_d       = pend_data_q;
               pend_valid_d = 1'b0;
               state_d      = CHECK_FIFO;
            end else if (uart_rx_rdy) begin
               data_d  = uart_rx_data;
               state_d = CHECK_FIFO;
            end
         end
         CHECK_FIFO: begin
            if (fifo_rx_full) begin
               w_ovf_set = 1'b1;
               state_d   = IDLE;
            end else begin
               wr_d    = 1'b1;
               din_d   = data_q;
               state_d = WRITE_FIFO;
            end
         end
         WRITE_FIFO: begin
            set_d   = 1'b1;
            state_d = UPDATE;
         end
         UPDATE: begin
            w_inc   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // In IDLE an arriving byte only needs the pending slot if the slot is
      // being unloaded this cycle; otherwise it went straight to data_reg.
      if (uart_rx_rdy) begin
         if (state_q == IDLE) begin
            if (pend_valid_q) begin
               pend_valid_d = 1'b1;
               pend_data_d  = uart_rx_data;
            end
         end else if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_data_d  = uart_rx_data;
         end else begin
            w_ovf_set = 1'b1;
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (w_ovf_set) begin
         ovf_d = 1'b1;
      end else if (overflow_clear) begin
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      count_d = count_q;
      if (count_clear) begin
         count_d = w_inc ? {{(COUNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (w_inc && (count_q != C_COUNT_MAX)) begin
         count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign fifo_rx_wr      = wr_q;
   assign fifo_rx_din     = din_q;
   assign recibir_bit_set = set_q;
   assign rx_overflow     = ovf_q;
   assign rx_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_rx.sv
`default_nettype none
// Scoreboard bench for fsm_rx: a transaction-level occupancy model predicts
// FIFO writes, set pulses, overflow and count; a forked monitor checks writes.
module tb_fsm_rx;

   localparam int DW = 8;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_rx_rdy = 1'b0;
   logic [DW-1:0] uart_rx_data = '0;
   logic          fifo_rx_full = 1'b0;
   logic          fifo_rx_wr;
   logic [DW-1:0] fifo_rx_din;
   logic          recibir_bit_set;
   logic          overflow_clear = 1'b0;
   logic          count_clear = 1'b0;
   logic          rx_overflow;
   logic [CW-1:0] rx_count;

   fsm_rx #(.DATA_W(DW), .COUNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .uart_rx_rdy     (uart_rx_rdy),
      .uart_rx_data    (uart_rx_data),
      .fifo_rx_full    (fifo_rx_full),
      .fifo_rx_wr      (fifo_rx_wr),
      .fifo_rx_din     (fifo_rx_din),
      .recibir_bit_set (recibir_bit_set),
      .overflow_clear  (overflow_clear),
      .count_clear     (count_clear),
      .rx_overflow     (rx_overflow),
      .rx_count        (rx_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_set[$];

   int checks = 0;
   int failures = 0;
   int t = 0;

   // Model: a byte accepted while the engine is free is examined one cycle
   // later; if it fits it is written the cycle after, then announced, then
   // counted. One byte may wait in a single-entry holding slot meanwhile.
   int            m_next_idle;
   int            m_check_at;
   int            m_inc_at;
   logic          m_infl;
   logic [DW-1:0] m_infl_d;
   logic          m_pend;
   logic [DW-1:0] m_pend_d;
   logic          m_ovf;
   int            m_cnt;

   task automatic model_reset();
      m_next_idle = t;
      m_check_at  = -1;
      m_inc_at    = -1;
      m_infl      = 1'b0;
      m_infl_d    = '0;
      m_pend      = 1'b0;
      m_pend_d    = '0;
      m_ovf       = 1'b0;
      m_cnt       = 0;
      exp_wr.delete();
      exp_set.delete();
   endtask

   task automatic model_step(input logic rdy, input logic [DW-1:0] d, input logic full,
                             input logic oc, input logic cc);
      logic drop;
      logic inc;
      wr_t  w;
      drop = 1'b0;
      inc  = (t == m_inc_at);
      if (m_infl && t == m_check_at) begin
         m_infl = 1'b0;
         if (full) begin
            drop        = 1'b1;
            m_next_idle = t + 1;
         end else begin
            w.d = m_infl_d;
            w.c = t + 1;
            exp_wr.push_back(w);
            exp_set.push_back(t + 2);
            m_inc_at    = t + 2;
            m_next_idle = t + 3;
         end
      end
      if (t >= m_next_idle) begin
         if (m_pend || rdy) begin
            m_infl      = 1'b1;
            m_infl_d    = m_pend ? m_pend_d : d;
            m_check_at  = t + 1;
            m_next_idle = t + 1000000;
            if (m_pend) begin
               m_pend   = rdy;
               m_pend_d = d;
            end
         end
      end else if (rdy) begin
         if (!m_pend) begin
            m_pend   = 1'b1;
            m_pend_d = d;
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
      if (cc) m_cnt = inc ? 1 : 0;
      else if (inc && m_cnt != CMAX) m_cnt = m_cnt + 1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, t, act, req);
      end
   endtask

   task automatic step(input logic rdy, input logic [DW-1:0] d, input logic full,
                       input logic oc, input logic cc);
      uart_rx_rdy    = rdy;
      uart_rx_data   = d;
      fifo_rx_full   = full;
      overflow_clear = oc;
      count_clear    = cc;
      model_step(rdy, d, full, oc, cc);
      @(posedge clk);
      #1;
      t++;
      chk("rx_overflow", int'(rx_overflow), int'(m_ovf));
      chk("rx_count", int'(rx_count), m_cnt);
   endtask

   task automatic idle(input int n, input logic full);
      for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), full, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      uart_rx_rdy    = 1'b1;
      uart_rx_data   = 8'hC3;
      overflow_clear = 1'b0;
      count_clear    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         t++;
      end
      rst         = 1'b0;
      uart_rx_rdy = 1'b0;
      model_reset();
      chk("reset_wr", int'(fifo_rx_wr), 0);
      chk("reset_din", int'(fifo_rx_din), 0);
      chk("reset_set", int'(recibir_bit_set), 0);
      chk("reset_ovf", int'(rx_overflow), 0);
      chk("reset_cnt", int'(rx_count), 0);
   endtask

   task automatic monitor();
      wr_t e;
      int  c;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fifo_rx_wr) begin
               checks++;
               if (exp_wr.size() == 0) begin
                  failures++;
                  $display("FAIL wr_unexpected cycle=%0d din=%h required=no write", t, fifo_rx_din);
               end else begin
                  e = exp_wr.pop_front();
                  if (fifo_rx_din !== e.d || t != e.c) begin
                     failures++;
                     $display("FAIL wr_data cycle=%0d din=%h required din=%h at cycle=%0d",
                              t, fifo_rx_din, e.d, e.c);
                  end
               end
            end
            if (recibir_bit_set) begin
               checks++;
               if (exp_set.size() == 0) begin
                  failures++;
                  $display("FAIL set_unexpected cycle=%0d required=no pulse", t);
               end else begin
                  c = exp_set.pop_front();
                  if (t != c) begin
                     failures++;
                     $display("FAIL set_cycle actual=%0d required=%0d", t, c);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      logic full_r;
      int   t0;
      model_reset();
      fork
         monitor();
      join_none

      do_reset();

      // single byte with fixed latency
      t0 = t;
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("lat_wr", int'(fifo_rx_wr), 1);
      chk("lat_din", int'(fifo_rx_din), 8'hA5);
      idle(1, 1'b0);
      chk("lat_set", int'(recibir_bit_set), 1);
      chk("lat_cycle", t - t0, 3);
      idle(3, 1'b0);
      chk("single_cnt", int'(rx_count), 1);

      // back-to-back
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      idle(10, 1'b0);
      chk("b2b_cnt", int'(rx_count), 2);
      chk("b2b_ovf", int'(rx_overflow), 0);

      // overrun on a third consecutive byte
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      idle(12, 1'b0);
      chk("overrun_ovf", int'(rx_overflow), 1);
      chk("overrun_cnt", int'(rx_count), 2);

      // FIFO full drops the byte
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("oclr_ovf", int'(rx_overflow), 0);
      step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b1);
      chk("full_ovf", int'(rx_overflow), 1);
      chk("full_cnt", int'(rx_count), 2);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("full_oclr", int'(rx_overflow), 0);

      // saturation, then clear coinciding with an increment
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
         idle(4, 1'b0);
      end
      chk("sat_cnt", int'(rx_count), 3);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_inc_cnt", int'(rx_count), 1);
      idle(4, 1'b0);

      // randomized traffic with a reset in the middle of it
      full_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) full_r = ~full_r;
         if (i == 1500) begin
            step(1'b1, DW'($urandom), full_r, 1'b0, 1'b0);
            do_reset();
         end
         step(($urandom_range(99) < 40), DW'($urandom), full_r,
              ($urandom_range(19) == 0), ($urandom_range(24) == 0));
      end
      idle(12, 1'b0);
      chk("drain_wr", exp_wr.size(), 0);
      chk("drain_set", exp_set.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fsm_rx.md
Name: fsm_rx

Overview:
- Receive-side companion of the UART TX control FSM.
- Takes each byte the UART receiver delivers (uart_rx_rdy pulse plus uart_rx_data) and writes it into the RX FIFO.
- Pulses a "new data" set strobe toward the control register and keeps a received-byte counter.
- Holds a sticky overflow flag for bytes dropped on FIFO full or receiver overrun.
- Sits between uart_rx and the RX FIFO / register bank, mirroring fsm_tx.

Parameters:
- DATA_W, 8, width of a received byte and of the FIFO write data.
- COUNT_W, 8, width of the received-byte counter (saturating).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- uart_rx_rdy  input  1  one-cycle pulse: uart_rx_data holds a valid byte.
- uart_rx_data  input  DATA_W  received byte, valid only while uart_rx_rdy=1.
- fifo_rx_full  input  1  RX FIFO full.
- fifo_rx_wr  output  1  one-cycle FIFO write strobe.
- fifo_rx_din  output  DATA_W  FIFO write data, valid while fifo_rx_wr=1.
- recibir_bit_set  output  1  one-cycle pulse to set the "new data" bit in the control register.
- overflow_clear  input  1  clears rx_overflow.
- count_clear  input  1  clears rx_count.
- rx_overflow  output  1  sticky: at least one byte was dropped.
- rx_count  output  COUNT_W  bytes successfully written to the FIFO since the last clear; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - fifo_rx_wr=0, fifo_rx_din=0, recibir_bit_set=0.
  - rx_overflow=0, rx_count=0.
  - Pending buffer empty.
  - Reset mid-operation aborts any in-flight byte; no write is issued afterwards.
- All outputs are registered.
- States: IDLE, CHECK_FIFO, WRITE_FIFO, UPDATE.
- IDLE:
  - If the pending buffer holds a byte, load it into data_reg, empty pending, go CHECK_FIFO.
  - Else if uart_rx_rdy=1, latch uart_rx_data into data_reg, go CHECK_FIFO.
  - Pending has priority over a simultaneous uart_rx_rdy. That new byte goes into pending, which is empty after the unload.
- CHECK_FIFO:
  - fifo_rx_full=1: drop data_reg, set rx_overflow, go IDLE.
  - Else go WRITE_FIFO.
- WRITE_FIFO:
  - fifo_rx_wr=1 for exactly this cycle, fifo_rx_din=data_reg.
  - Go UPDATE.
- UPDATE:
  - recibir_bit_set=1 for exactly this cycle.
  - rx_count increments by 1 unless already at 2^COUNT_W-1.
  - Go IDLE.
- Latency: uart_rx_rdy in cycle N gives fifo_rx_wr in N+2 and recibir_bit_set in N+3 (IDLE, no pending, FIFO not full).
- uart_rx_rdy in a non-IDLE state:
  - If pending is empty, store the byte in pending.
  - If pending is full, drop the byte and set rx_overflow. Pending keeps the older byte.
- Pending holds one entry and is loaded from uart_rx_data in the same cycle.
- rx_overflow: set has priority over overflow_clear in the same cycle (it stays 1).
- rx_count:
  - count_clear together with an UPDATE increment gives rx_count=1.
  - count_clear alone gives 0.
- fifo_rx_wr is never asserted when fifo_rx_full was 1 in the preceding CHECK_FIFO cycle.
- fifo_rx_wr is never asserted two cycles in a row.
- A byte is written at most once and in arrival order.

Test Plan:
- Reset: hold rst=1 for 2 cycles with uart_rx_rdy=1 -> all outputs 0, no fifo_rx_wr afterwards; state IDLE.
- Single byte: fifo_rx_full=0, pulse uart_rx_rdy with 0xA5 at cycle N -> fifo_rx_wr=1, fifo_rx_din=0xA5 at N+2; recibir_bit_set=1 at N+3; rx_count=1.
- Back-to-back: rdy pulses with 0x11 at N and 0x22 at N+1 -> writes 0x11 then 0x22, in order, no overflow; rx_count=2.
- Overrun: rdy pulses with 0x01, 0x02, 0x03 on three consecutive cycles -> 0x01 and 0x02 written, 0x03 dropped; rx_overflow=1, rx_count=2.
- FIFO full: fifo_rx_full=1, send 0x5A -> no fifo_rx_wr, rx_overflow=1, rx_count unchanged.
  - Then pulse overflow_clear -> rx_overflow=0.
- Saturation/clear: COUNT_W=2, send 5 bytes -> rx_count=3.
  - count_clear during the UPDATE of a 6th byte -> rx_count=1.
